// File: rtl/avalon_dct_mc.sv
// Avalon-MM DCT-II / DCT-III peripheral: run-time length, saturating results,
// status register and a read-stall handshake on the result window.
module avalon_dct_mc #(
   parameter int         MAX_SIZE            = 64,
   parameter int         HEIGHT              = $clog2(MAX_SIZE),
   parameter int         NBITS               = 16,
   parameter int         NUM_TERMS_PER_CYCLE = 8,
   parameter int         ACC_W               = NBITS + HEIGHT + 2,
   parameter logic [7:0] RES_BASE            = 8'h80
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [7:0]       address,
   input  logic             read,
   input  logic             write,
   input  logic [NBITS-1:0] writedata,
   output logic [NBITS-1:0] out,
   output logic             done
);

   localparam int T         = NUM_TERMS_PER_CYCLE;
   localparam int CW        = HEIGHT + 1;
   localparam int CIDX_MASK = 2 * MAX_SIZE - 1;
   localparam int PW        = NBITS + 16;

   // Bus handshake: a read completes in the cycle done is high; done only
   // drops for an unwritten result slot inside the current length.
   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LOAD  = 3'd1,
      S_ACC   = 3'd2,
      S_STORE = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t                   r_state;
   state_t                   w_state_nxt;
   logic [3:0]               r_p;
   logic                     r_inv;
   logic [CW-1:0]            r_n;
   logic [CW-1:0]            r_k;
   logic [CW-1:0]            r_j;
   logic [CW-1:0]            r_out_idx;
   logic signed [ACC_W-1:0]  r_acc;
   logic [NBITS-1:0]         r_m;
   logic [MAX_SIZE-1:0]      r_valid;
   logic signed [NBITS-1:0]  r_sample [MAX_SIZE];
   logic [NBITS-1:0]         r_result [MAX_SIZE];

   logic                     w_ctrl_wr;
   logic                     w_data_wr;
   logic                     w_setq_wr;
   logic                     w_last_sample;
   logic                     w_acc_last;
   logic                     w_store_last;
   logic [3:0]               w_p_req;
   logic [3:0]               w_p_new;
   logic signed [ACC_W-1:0]  w_sum;
   logic [ACC_W-NBITS:0]     w_acc_hi;
   logic                     w_fits;
   logic [NBITS-1:0]         w_sat;
   logic [7:0]               w_res_i;
   logic                     w_unused;

   // Quarter-wave Q1.15 cosine table for a 64-point grid; smaller MAX_SIZE
   // values stride through it (MAX_SIZE must be a power of two <= 64).
   function automatic logic signed [15:0] dct_rom(input int m);
      int                  q;
      int                  qq;
      logic signed [15:0]  v;
      q  = m * (64 / MAX_SIZE);
      qq = (q > 32) ? 64 - q : q;
      case (qq)
         0:  v = 16'sd32767;  1:  v = 16'sd32728;  2:  v = 16'sd32609;
         3:  v = 16'sd32412;  4:  v = 16'sd32137;  5:  v = 16'sd31785;
         6:  v = 16'sd31356;  7:  v = 16'sd30852;  8:  v = 16'sd30273;
         9:  v = 16'sd29621;  10: v = 16'sd28898;  11: v = 16'sd28105;
         12: v = 16'sd27245;  13: v = 16'sd26319;  14: v = 16'sd25329;
         15: v = 16'sd24279;  16: v = 16'sd23170;  17: v = 16'sd22005;
         18: v = 16'sd20787;  19: v = 16'sd19519;  20: v = 16'sd18204;
         21: v = 16'sd16846;  22: v = 16'sd15446;  23: v = 16'sd14010;
         24: v = 16'sd12539;  25: v = 16'sd11039;  26: v = 16'sd9512;
         27: v = 16'sd7962;   28: v = 16'sd6393;   29: v = 16'sd4808;
         30: v = 16'sd3212;   31: v = 16'sd1608;
         default: v = 16'sd0;
      endcase
      return (q > 32) ? -v : v;
   endfunction

   function automatic logic signed [15:0] cos_coef(input int idx);
      int m;
      m = (idx > MAX_SIZE) ? 2 * MAX_SIZE - idx : idx;
      return dct_rom(m);
   endfunction

   assign w_ctrl_wr     = write && (address == 8'd0);
   assign w_data_wr     = write && (address == 8'd1) && (r_state == S_LOAD);
   assign w_setq_wr     = write && (address == 8'd2);
   assign w_last_sample = (r_k == r_n - CW'(1));
   assign w_acc_last    = (int'(r_j) + T) >= int'(r_n);
   assign w_store_last  = (r_out_idx == r_n - CW'(1));
   assign w_p_req       = writedata[3:0];
   assign w_p_new       = (int'(w_p_req) > HEIGHT) ? 4'(HEIGHT) : w_p_req;
   assign w_unused      = ^r_m;

   // T parallel multiply-accumulate lanes over sample/term indices j..j+T-1.
   always_comb begin : term_sum
      int                      n;
      int                      a;
      int                      b;
      int                      idx;
      logic signed [15:0]      coef;
      logic signed [PW-1:0]    prod;
      logic signed [ACC_W-1:0] term;
      n     = 0;
      a     = 0;
      b     = 0;
      idx   = 0;
      coef  = '0;
      prod  = '0;
      term  = '0;
      w_sum = '0;
      for (int t = 0; t < T; t++) begin
         n    = int'(r_j) + t;
         a    = r_inv ? int'(r_out_idx) : n;
         b    = r_inv ? n : int'(r_out_idx);
         idx  = ((((2 * a + 1) * b) << HEIGHT) >> (int'(r_p) + 1)) & CIDX_MASK;
         coef = cos_coef(idx);
         prod = PW'(r_sample[HEIGHT'(n)]) * PW'(coef);
         term = ACC_W'(prod >>> (NBITS - 1));
         if (r_inv && (n == 0)) begin
            term = term >>> 1;
         end
         if (n < int'(r_n)) begin
            w_sum = w_sum + term;
         end
      end
   end

   assign w_acc_hi = r_acc[ACC_W-1:NBITS-1];
   assign w_fits   = (&w_acc_hi) | ~(|w_acc_hi);
   assign w_sat    = w_fits ? r_acc[NBITS-1:0]
                   : (r_acc[ACC_W-1] ? {1'b1, {(NBITS-1){1'b0}}}
                                     : {1'b0, {(NBITS-1){1'b1}}});

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      if (w_ctrl_wr) begin
         w_state_nxt = S_LOAD;
      end else begin
         case (r_state)
            S_LOAD:  if (w_data_wr && w_last_sample) w_state_nxt = S_ACC;
            S_ACC:   if (w_acc_last) w_state_nxt = S_STORE;
            S_STORE: w_state_nxt = w_store_last ? S_DONE : S_ACC;
            default: w_state_nxt = r_state;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_p       <= '0;
         r_inv     <= 1'b0;
         r_n       <= CW'(1);
         r_k       <= '0;
         r_j       <= '0;
         r_out_idx <= '0;
         r_acc     <= '0;
         r_m       <= '0;
         r_valid   <= '0;
      end else begin
         if (w_setq_wr) begin
            r_m <= writedata;
         end
         if (w_ctrl_wr) begin
            r_p       <= w_p_new;
            r_inv     <= writedata[4];
            r_n       <= CW'(1) << w_p_new;
            r_k       <= '0;
            r_j       <= '0;
            r_out_idx <= '0;
            r_acc     <= '0;
            r_valid   <= '0;
         end else begin
            case (r_state)
               S_LOAD: begin
                  if (w_data_wr) begin
                     r_k <= r_k + CW'(1);
                     if (w_last_sample) begin
                        r_out_idx <= '0;
                        r_j       <= '0;
                        r_acc     <= '0;
                     end
                  end
               end
               S_ACC: begin
                  r_acc <= r_acc + w_sum;
                  r_j   <= r_j + CW'(T);
               end
               S_STORE: begin
                  r_valid[r_out_idx[HEIGHT-1:0]] <= 1'b1;
                  r_out_idx <= r_out_idx + CW'(1);
                  r_j       <= '0;
                  r_acc     <= '0;
               end
               default: ;
            endcase
         end
      end
   end

   // Sample and result storage carry no reset; result_valid guards reads.
   always_ff @(posedge clk) begin
      if (w_data_wr) begin
         r_sample[r_k[HEIGHT-1:0]] <= writedata;
      end
      if ((r_state == S_STORE) && !w_ctrl_wr) begin
         r_result[r_out_idx[HEIGHT-1:0]] <= w_sat;
      end
   end

   assign w_res_i = address - RES_BASE;

   always_comb begin
      out  = '0;
      done = 1'b1;
      if (read) begin
         if (address == 8'd3) begin
            out = NBITS'({r_inv, r_state, 9'(r_out_idx)});
         end else if ((address >= RES_BASE) && (int'(w_res_i) < int'(r_n))) begin
            out  = r_result[w_res_i[HEIGHT-1:0]];
            done = r_valid[w_res_i[HEIGHT-1:0]];
         end
      end
   end

endmodule
